// File: rtl/av_burst_master_pkg.sv
// Shared types and constants for the Avalon-MM burst initiator.
package av_burst_master_pkg;

    localparam int unsigned AV_MAX_BURST = 7;
    localparam int unsigned AV_LEN_W     = $clog2(AV_MAX_BURST + 1);

    localparam logic [1:0] AV_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AV_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AV_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR      = 2'd1,
        ST_RD_REQ  = 2'd2,
        ST_RD_DATA = 2'd3
    } av_state_e;

    // A zero-length command still moves one beat.
    function automatic logic [AV_LEN_W-1:0] eff_len(input logic [AV_LEN_W-1:0] len);
        return (len == '0) ? AV_LEN_W'(1) : len;
    endfunction

    // Reserved encoding 2'b01 is treated as an error as well.
    function automatic logic resp_is_err(input logic [1:0] resp);
        case (resp)
            AV_RESP_OKAY:                   return 1'b0;
            AV_RESP_SLVERR, AV_RESP_DECERR: return 1'b1;
            default:                        return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/av_burst_master_watchdog.sv
// Progress watchdog: cleared on load/kick or while inactive, otherwise counts up
// and flags expiry at TIMEOUT (TIMEOUT=0 disables it).
module av_burst_master_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic kick_i,
    input  logic active_i,
    output logic expire_o
);

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire_o = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));

    always_comb begin
        cnt_d = cnt_q;
        if (load_i || kick_i || !active_i) begin
            cnt_d = '0;
        end else if (!expire_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/av_burst_master.sv
// Avalon-MM burst initiator: one read or write burst of 1-7 beats per accepted command.
module av_burst_master
    import av_burst_master_pkg::*;
#(
    parameter int unsigned dw      = 32,
    parameter int unsigned aw      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                av_clk_i,
    input  logic                av_rst_ni,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [aw-1:0]       cmd_adr_i,
    input  logic [2:0]          cmd_len_i,
    input  logic [dw/8-1:0]     cmd_be_i,
    input  logic [dw-1:0]       wr_data_i,
    input  logic                wr_valid_i,
    output logic                wr_ready_o,
    output logic [dw-1:0]       rd_data_o,
    output logic                rd_valid_o,
    output logic                done_o,
    output logic                err_o,
    output logic [aw-1:0]       av_address_o,
    output logic [2:0]          av_burstcount_o,
    output logic [dw/8-1:0]     av_byteenable_o,
    output logic [dw-1:0]       av_writedata_o,
    output logic                av_write_o,
    output logic                av_read_o,
    input  logic                av_waitrequest_i,
    input  logic                av_readdatavalid_i,
    input  logic [1:0]          av_response_i,
    input  logic [dw-1:0]       av_readdata_i
);

    localparam int unsigned BW = dw / 8;

    av_state_e             state_q, state_d;
    logic [AV_LEN_W-1:0]   beats_q, beats_d;
    logic [AV_LEN_W-1:0]   bc_q, bc_d;
    logic [aw-1:0]         adr_q, adr_d;
    logic [BW-1:0]         be_q, be_d;
    logic [dw-1:0]         rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  cmd_ready_q, cmd_ready_d;

    logic accept_c, wr_beat_c, req_ok_c, rd_beat_c, expire_c;

    // Avalon strobes follow the live write stream; the watchdog pulls them on abort.
    assign accept_c       = cmd_valid_i && cmd_ready_q;
    assign av_write_o     = (state_q == ST_WR) && wr_valid_i && !expire_c;
    assign wr_ready_o     = (state_q == ST_WR) && !av_waitrequest_i && !expire_c;
    assign av_writedata_o = (state_q == ST_WR) ? wr_data_i : '0;
    assign av_read_o      = (state_q == ST_RD_REQ) && !expire_c;
    assign wr_beat_c      = av_write_o && !av_waitrequest_i;
    assign req_ok_c       = av_read_o && !av_waitrequest_i;
    assign rd_beat_c      = (state_q == ST_RD_DATA) && av_readdatavalid_i && !expire_c;

    assign cmd_ready_o     = cmd_ready_q;
    assign rd_data_o       = rd_data_q;
    assign rd_valid_o      = rd_valid_q;
    assign done_o          = done_q;
    assign err_o           = err_q;
    assign av_address_o    = adr_q;
    assign av_burstcount_o = bc_q;
    assign av_byteenable_o = be_q;

    av_burst_master_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk      (av_clk_i),
        .rst_n    (av_rst_ni),
        .load_i   (accept_c),
        .kick_i   (wr_beat_c || req_ok_c || rd_beat_c),
        .active_i (state_q != ST_IDLE),
        .expire_o (expire_c)
    );

    // Next-state and datapath.
    always_comb begin
        state_d    = state_q;
        beats_d    = beats_q;
        bc_d       = bc_q;
        adr_d      = adr_q;
        be_d       = be_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    adr_d   = cmd_adr_i;
                    be_d    = cmd_be_i;
                    bc_d    = eff_len(cmd_len_i);
                    beats_d = eff_len(cmd_len_i);
                    err_d   = 1'b0;
                    state_d = cmd_we_i ? ST_WR : ST_RD_REQ;
                end
            end
            ST_WR: begin
                if (wr_beat_c) begin
                    beats_d = beats_q - AV_LEN_W'(1);
                    if (beats_q == AV_LEN_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_RD_REQ: begin
                if (req_ok_c) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (rd_beat_c) begin
                    rd_data_d  = av_readdata_i;
                    rd_valid_d = 1'b1;
                    if (resp_is_err(av_response_i)) err_d = 1'b1;
                    beats_d = beats_q - AV_LEN_W'(1);
                    if (beats_q == AV_LEN_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (expire_c) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
        end

        // Hold off new commands during the done cycle.
        cmd_ready_d = (state_d == ST_IDLE) && !done_d;
    end

    always_ff @(posedge av_clk_i or negedge av_rst_ni) begin
        if (!av_rst_ni) begin
            state_q     <= ST_IDLE;
            beats_q     <= '0;
            bc_q        <= '0;
            adr_q       <= '0;
            be_q        <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beats_q     <= beats_d;
            bc_q        <= bc_d;
            adr_q       <= adr_d;
            be_q        <= be_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

endmodule
